imem_loader: RTL
================

Name: imem_loader

Overview:
- Front-panel writer for the CPU instruction memory.
- Builds 32-bit instruction words from two 16-bit switch entries, each latched by a debounced button press.
- Writes each completed word to the instruction RAM at an auto-incrementing address, then reads it back and checks it.
- Sits between the board buttons/switches and the instruction RAM write port; the CPU fetch path uses the RAM's read port.

Parameters:
- ADDR_W, 10, instruction RAM address width (1024 words).
- DEB_CYCLES, 16, consecutive stable synchronized samples needed to change a debounced button level.
- RD_LAT, 1, RAM read latency in cycles from address presented to mem_dout valid.

Ports:
- clk  in  1  system clock; all state on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- btn_latch  in  1  raw push button; each press latches the switch value as the next half-word.
- btn_clr  in  1  raw push button; clears the address and error state.
- switch  in  16  half-word data value.
- mem_addr  out  ADDR_W  RAM address, used for both write and readback.
- mem_din  out  32  RAM write data.
- mem_we  out  1  RAM write enable, one-cycle pulse.
- mem_dout  in  32  RAM read data.
- word_count  out  ADDR_W+1  number of words committed since clear.
- half_pending  out  1  low half latched, high half not yet latched.
- busy  out  1  high in WRITE and VERIFY.
- full  out  1  last address written; further presses ignored.
- verify_err  out  1  sticky readback-mismatch flag.
- err_addr  out  ADDR_W  address of the first mismatch.

Behaviour:
- Reset (async, rst_n=0): all outputs 0; FSM in WAIT_LO; internal lo/hi registers 0; debounced levels 0.
- Button conditioning (each button):
  - Raw input passes through a 2-FF synchronizer.
  - The debounced level flips only after DEB_CYCLES consecutive cycles of synchronized value differing from the current level.
  - A debounced 0->1 transition gives exactly one 1-cycle pulse. Pulse timing: DEB_CYCLES+1 to DEB_CYCLES+3 cycles after the raw rising edge.
  - Glitches shorter than DEB_CYCLES produce no pulse.
  - Releasing a button produces no pulse.
- FSM states and transitions:
  - WAIT_LO: on latch pulse and !full, lo<=switch, half_pending<=1, go to WAIT_HI.
  - WAIT_HI: on latch pulse, hi<=switch, half_pending<=0, go to WRITE.
  - WRITE (exactly 1 cycle): mem_we=1, mem_addr=addr, mem_din={hi,lo}. Go to VERIFY.
  - VERIFY: mem_we=0, mem_addr holds. Wait RD_LAT cycles, then compare mem_dout to {hi,lo} in the following cycle.
    - On mismatch with verify_err=0: verify_err<=1, err_addr<=addr. verify_err is sticky.
    - Then word_count+=1.
    - If addr==2^ADDR_W-1: full<=1 and addr holds. Otherwise addr+=1.
    - Go to WAIT_LO.
- busy = (state==WRITE || state==VERIFY).
- Latch pulses in WRITE or VERIFY are dropped, not queued. Latch pulses while full=1 are ignored.
- mem_din holds its last value outside WRITE. mem_addr always equals the current addr.
- Clear pulse, accepted in any state:
  - Next cycle: addr=0, word_count=0, full=0, verify_err=0, err_addr=0, half_pending=0, state=WAIT_LO, mem_we=0.
  - A clear during WRITE or VERIFY aborts the verify. The word already written stays in RAM but is not counted.
- Clear and latch pulses in the same cycle: clear wins; the latch is discarded.
- Async reset mid-operation: immediate return to reset values, including the debounce counters.
- Write-to-next-ready latency: 2+RD_LAT cycles from entering WRITE to returning to WAIT_LO.

Test Plan:
Bench uses DEB_CYCLES=4, RD_LAT=1, a behavioral 1-cycle RAM, and holds each press 10 cycles.
1. Press latch with switch=16'h1234, then with switch=16'hABCD -> exactly one mem_we pulse; mem_addr=0, mem_din=32'hABCD1234; word_count=1; verify_err=0; next word goes to addr 1.
2. 3-cycle glitch on btn_latch -> no pulse; half_pending stays 0; no write.
3. RAM model forced to return 32'hDEADBEEF for addr 2 while writing 3 words -> verify_err=1, err_addr=2; word_count=3; error stays set after a 4th word.
4. Preload addr to 1023 via 1023 writes, then write 1 word -> full=1, word_count=1024; further presses give no mem_we; clear -> full=0, addr=0, word_count=0.
5. Clear pressed during WRITE/VERIFY, and clear+latch pulses in the same cycle -> state WAIT_LO, half_pending=0, word_count unchanged from 0, no extra mem_we.
6. rst_n low mid-VERIFY -> all outputs 0 asynchronously; after release, the first full press pair writes to addr 0.

Source files
------------

// File: rtl/imem_loader.sv
// Front-panel instruction memory loader: two debounced buttons, a 16-bit switch
// bank, and a small FSM that assembles 32-bit words, writes them to the
// instruction RAM at an auto-incrementing address and reads each one back.

// Button conditioner: 2-FF synchronizer, stable-level debounce, rising-edge pulse.
module imem_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic pulse_o
);
    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

    logic [1:0]    sync_q;
    logic          level_q;
    logic [CW-1:0] cnt_q;
    logic          pulse_q;

    // Count consecutive disagreeing samples; flip the level (and pulse on a rise) on the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b00;
            level_q <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            pulse_q <= 1'b0;
            if (sync_q[1] != level_q) begin
                if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                    level_q <= sync_q[1];
                    cnt_q   <= '0;
                    pulse_q <= sync_q[1];
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign pulse_o = pulse_q;
endmodule

module imem_loader #(
    parameter int ADDR_W     = 10,
    parameter int DEB_CYCLES = 16,
    parameter int RD_LAT     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_latch,
    input  logic              btn_clr,
    input  logic [15:0]       switch,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic              mem_we,
    input  logic [31:0]       mem_dout,
    output logic [ADDR_W:0]   word_count,
    output logic              half_pending,
    output logic              busy,
    output logic              full,
    output logic              verify_err,
    output logic [ADDR_W-1:0] err_addr,
    output logic [1:0]        dbg_state
);
    localparam int VW = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;

    typedef enum logic [1:0] {
        S_WAIT_LO = 2'd0,
        S_WAIT_HI = 2'd1,
        S_WRITE   = 2'd2,
        S_VERIFY  = 2'd3
    } state_t;

    logic latch_p, clr_p;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       lo_q, lo_d, hi_q, hi_d;
    logic [31:0]       din_q, din_d;
    logic [ADDR_W:0]   wc_q, wc_d;
    logic              half_q, half_d;
    logic              full_q, full_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic [VW-1:0]     vcnt_q, vcnt_d;

    imem_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_latch (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (btn_latch),
        .pulse_o(latch_p)
    );

    imem_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (btn_clr),
        .pulse_o(clr_p)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_WAIT_LO;
            addr_q     <= '0;
            lo_q       <= '0;
            hi_q       <= '0;
            din_q      <= '0;
            wc_q       <= '0;
            half_q     <= 1'b0;
            full_q     <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
            vcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            din_q      <= din_d;
            wc_q       <= wc_d;
            half_q     <= half_d;
            full_q     <= full_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            vcnt_q     <= vcnt_d;
        end
    end

    // Next-state logic; a clear pulse overrides everything, including a same-cycle latch.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        din_d      = din_q;
        wc_d       = wc_q;
        half_d     = half_q;
        full_d     = full_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        vcnt_d     = vcnt_q;
        if (clr_p) begin
            state_d    = S_WAIT_LO;
            addr_d     = '0;
            wc_d       = '0;
            half_d     = 1'b0;
            full_d     = 1'b0;
            err_d      = 1'b0;
            err_addr_d = '0;
            vcnt_d     = '0;
        end else begin
            case (state_q)
                S_WAIT_LO: begin
                    if (latch_p && !full_q) begin
                        lo_d    = switch;
                        half_d  = 1'b1;
                        state_d = S_WAIT_HI;
                    end
                end
                S_WAIT_HI: begin
                    if (latch_p) begin
                        hi_d    = switch;
                        din_d   = {switch, lo_q};
                        half_d  = 1'b0;
                        state_d = S_WRITE;
                    end
                end
                S_WRITE: begin
                    vcnt_d  = '0;
                    state_d = S_VERIFY;
                end
                S_VERIFY: begin
                    // Read data is valid RD_LAT cycles after the address; compare then.
                    if (vcnt_q == VW'(RD_LAT)) begin
                        if ((mem_dout != {hi_q, lo_q}) && !err_q) begin
                            err_d      = 1'b1;
                            err_addr_d = addr_q;
                        end
                        wc_d = wc_q + (ADDR_W+1)'(1);
                        if (addr_q == {ADDR_W{1'b1}}) begin
                            full_d = 1'b1;
                        end else begin
                            addr_d = addr_q + ADDR_W'(1);
                        end
                        state_d = S_WAIT_LO;
                    end else begin
                        vcnt_d = vcnt_q + VW'(1);
                    end
                end
                default: state_d = S_WAIT_LO;
            endcase
        end
    end

    assign mem_we       = (state_q == S_WRITE);
    assign busy         = (state_q == S_WRITE) || (state_q == S_VERIFY);
    assign mem_addr     = addr_q;
    assign mem_din      = din_q;
    assign word_count   = wc_q;
    assign half_pending = half_q;
    assign full         = full_q;
    assign verify_err   = err_q;
    assign err_addr     = err_addr_q;
    assign dbg_state    = state_q;
endmodule
